// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, responder FSM states and small decode helpers.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Oversized transfers and accesses not aligned to their own size are rejected.
    function automatic logic is_illegal(input logic [2:0] size, input logic [1:0] off);
        case (size)
            HSIZE_BYTE: is_illegal = 1'b0;
            HSIZE_HALF: is_illegal = off[0];
            HSIZE_WORD: is_illegal = (off != 2'b00);
            default:    is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] off);
        case (size)
            HSIZE_BYTE: byte_enable = 4'b0001 << off;
            HSIZE_HALF: byte_enable = 4'b0011 << off;
            default:    byte_enable = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ram_be32.sv
// 2^AW x 32 register-array RAM: byte-enabled synchronous write, asynchronous read.
module ram_be32 #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahbl_ram_slave.sv
// AHB-Lite responder in front of a byte-writable RAM with programmable wait states
// and a two-cycle ERROR response for illegal sizes or misaligned accesses.
module ahbl_ram_slave
    import ahbl_pkg::*;
#(
    parameter int unsigned AW          = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [AW+1:0] addr_q, addr_n;
    logic          write_q, write_n;
    logic [2:0]    size_q, size_n;

    logic          ready_state;
    logic          accept;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    logic          unused;
    assign unused = ^{HADDR[31:AW+2], HTRANS[0]};

    // A new address phase is only taken in cycles where this slave signals ready.
    assign ready_state = (state == ST_IDLE) || (state == ST_ERR2) ||
                         ((state == ST_DATA) && (cnt == '0));
    assign accept = HSEL && HTRANS[1] && HREADY && ready_state;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            write_q <= write_n;
            size_q  <= size_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        write_n = write_q;
        size_n  = size_q;
        if (state == ST_DATA && cnt != '0) begin
            cnt_n = cnt - 4'd1;
        end else if (state == ST_ERR1) begin
            state_n = ST_ERR2;
        end else if (accept) begin
            addr_n  = HADDR[AW+1:0];
            write_n = HWRITE;
            size_n  = HSIZE;
            if (is_illegal(HSIZE, HADDR[1:0])) begin
                state_n = ST_ERR1;
                cnt_n   = '0;
            end else begin
                state_n = ST_DATA;
                cnt_n   = WS;
            end
        end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
        end
    end

    assign ram_we    = (state == ST_DATA) && (cnt == '0) && write_q;
    assign HREADYOUT = !((state == ST_DATA) && (cnt != '0)) && (state != ST_ERR1);
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = ((state == ST_DATA) && !write_q) ? ram_rdata : '0;

    ram_be32 #(.AW(AW)) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .be    (byte_enable(size_q, addr_q[1:0])),
        .addr  (addr_q[AW+1:2]),
        .wdata (HWDATA),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ahbl_ram_slave.sv
// Self-checking bench: three responders (0, 3 and 2 wait states) share one bus driver;
// HSEL steers transfers to the active one and a byte-level model predicts responses.
module tb_ahbl_ram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          active;

    logic        rdy [3];
    logic        rsp [3];
    logic [31:0] rdt [3];

    logic        ro, rr;
    logic [31:0] rd;

    int n_cmp = 0;
    int n_err = 0;
    int ws [3] = '{0, 3, 2};

    logic [7:0] mm [3][4096];

    always #5 clk = ~clk;

    ahbl_ram_slave #(.AW(10), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && active == 0), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(rdy[0]), .HREADYOUT(rdy[0]), .HRESP(rsp[0]), .HRDATA(rdt[0]));

    ahbl_ram_slave #(.AW(10), .WAIT_STATES(3)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && active == 1), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(rdy[1]), .HREADYOUT(rdy[1]), .HRESP(rsp[1]), .HRDATA(rdt[1]));

    ahbl_ram_slave #(.AW(10), .WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel && active == 2), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(rdy[2]), .HREADYOUT(rdy[2]), .HRESP(rsp[2]), .HRDATA(rdt[2]));

    always_comb begin
        ro = rdy[active];
        rr = rsp[active];
        rd = rdt[active];
    end

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_resp;
        int          exp_waits;
    } vec_t;

    function automatic vec_t mk(int k, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd,
                                logic [31:0] erd, bit ersp, int ew);
        vec_t v;
        v.k = k; v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd;
        v.exp_rd = erd; v.exp_resp = ersp; v.exp_waits = ew;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit illegal(logic [31:0] a, logic [2:0] sz);
        if (sz > 3'd2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    task automatic model_write(int k, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        int off = int'(a % 4);
        for (int i = 0; i < (1 << sz); i++) mm[k][int'(a % 4096) + i] = wd[8*(off+i) +: 8];
    endtask

    function automatic logic [31:0] model_read(int k, logic [31:0] a);
        int b = int'(a % 4096) - int'(a % 4);
        return {mm[k][b+3], mm[k][b+2], mm[k][b+1], mm[k][b]};
    endfunction

    // Single non-pipelined transfer on the active responder.
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                        output logic [31:0] rdv, output logic respv, output int waits, output logic resp_first);
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
        @(posedge clk);
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        waits = 0;
        resp_first = rr;
        while (!ro && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        rdv = rd;
        respv = rr;
        @(posedge clk);
    endtask

    task automatic run_vec(vec_t v, string tag);
        logic [31:0] r; logic rs, rf; int w;
        active = v.k;
        xfer(v.wr, v.addr, v.size, v.wdata, r, rs, w, rf);
        chk({tag, " rdata"}, r, v.exp_rd);
        chk({tag, " resp"}, 32'(rs), 32'(v.exp_resp));
        chk({tag, " resp_first"}, 32'(rf), 32'(v.exp_resp));
        chk({tag, " waits"}, 32'(w), 32'(v.exp_waits));
        if (!v.exp_resp && v.wr) model_write(v.k, v.addr, v.size, v.wdata);
    endtask

    task automatic run_model(int k, bit wr, logic [31:0] a, logic [2:0] sz, logic [31:0] wd);
        bit bad = illegal(a, sz);
        logic [31:0] erd = (!bad && !wr) ? model_read(k, a) : 32'h0;
        run_vec(mk(k, wr, a, sz, wd, erd, bad, bad ? 1 : ws[k]), "rand");
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; active = 0;

        tbl.push_back(mk(0, 1, 32'h10,       3'd2, 32'hDEADBEEF, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 32'h10,       3'd2, 32'h0,        32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 1, 32'h0,        3'd2, 32'h0,        32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 32'h2,        3'd0, 32'h00AB0000, 32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 32'h0,        3'd1, 32'h00001234, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        3'd2, 32'h0,        32'h00AB1234, 0, 0));
        tbl.push_back(mk(0, 1, 32'h2,        3'd2, 32'h11111111, 32'h0,        1, 1));
        tbl.push_back(mk(0, 1, 32'h1,        3'd1, 32'h22222222, 32'h0,        1, 1));
        tbl.push_back(mk(0, 1, 32'h0,        3'd3, 32'h33333333, 32'h0,        1, 1));
        tbl.push_back(mk(0, 0, 32'h0,        3'd2, 32'h0,        32'h00AB1234, 0, 0));
        tbl.push_back(mk(0, 0, 32'hFFFFF010, 3'd2, 32'h0,        32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(0, 1, 32'h3,        3'd0, 32'hCD000000, 32'h0,        0, 0));
        tbl.push_back(mk(0, 1, 32'h2,        3'd1, 32'h56780000, 32'h0,        0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        3'd2, 32'h0,        32'h56781234, 0, 0));
        tbl.push_back(mk(1, 1, 32'h20,       3'd2, 32'hCAFEF00D, 32'h0,        0, 3));
        tbl.push_back(mk(1, 1, 32'h24,       3'd2, 32'h600DD00D, 32'h0,        0, 3));
        tbl.push_back(mk(1, 0, 32'h20,       3'd2, 32'h0,        32'hCAFEF00D, 0, 3));
        tbl.push_back(mk(1, 0, 32'h22,       3'd2, 32'h0,        32'h0,        1, 1));
        tbl.push_back(mk(2, 1, 32'h4,        3'd2, 32'h11111111, 32'h0,        0, 2));

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset hreadyout %0d", k), 32'(rdy[k]), 32'h1);
            chk($sformatf("reset hresp %0d", k), 32'(rsp[k]), 32'h0);
            chk($sformatf("reset hrdata %0d", k), rdt[k], 32'h0);
        end
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Zero-wait pipelined write then read of the same word.
        active = 0;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h18; hsize = 3'd2;
        @(posedge clk);
        @(negedge clk);
        chk("b2b write ready", 32'(ro), 32'h1);
        hwdata = 32'hDEADBEEF; hwrite = 1'b0; htrans = 2'b11;
        @(posedge clk);
        @(negedge clk);
        chk("b2b read ready", 32'(ro), 32'h1);
        chk("b2b read data", rd, 32'hDEADBEEF);
        hsel = 1'b0; htrans = 2'b00;
        @(posedge clk);
        model_write(0, 32'h18, 3'd2, 32'hDEADBEEF);

        // Two back-to-back reads at three wait states.
        begin
            int edges = 0, lows = 0, done = 0;
            logic [31:0] r [2];
            active = 1;
            @(negedge clk);
            hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h20; hsize = 3'd2;
            @(posedge clk);
            @(negedge clk);
            haddr = 32'h24;
            while (done < 2 && edges < 30) begin
                if (!ro) lows++;
                else begin
                    r[done] = rd;
                    done++;
                    if (done == 2) begin hsel = 1'b0; htrans = 2'b00; end
                end
                @(posedge clk);
                edges++;
                if (done < 2) @(negedge clk);
            end
            chk("ws3 b2b edges", 32'(edges), 32'd8);
            chk("ws3 b2b low cycles", 32'(lows), 32'd6);
            chk("ws3 b2b data0", r[0], 32'hCAFEF00D);
            chk("ws3 b2b data1", r[1], 32'h600DD00D);
        end

        // BUSY while selected, then NONSEQ while unselected: both must be ignored.
        active = 0;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b01; hwrite = 1'b0; haddr = 32'h10; hsize = 3'd2;
        @(posedge clk);
        @(negedge clk);
        chk("busy ready", 32'(ro), 32'h1);
        chk("busy resp", 32'(rr), 32'h0);
        chk("busy rdata", rd, 32'h0);
        hsel = 1'b0; htrans = 2'b10;
        @(posedge clk);
        @(negedge clk);
        chk("unsel ready", 32'(ro), 32'h1);
        chk("unsel resp", 32'(rr), 32'h0);
        chk("unsel rdata", rd, 32'h0);
        htrans = 2'b00;

        // Reset during the first wait cycle of a write drops the write.
        active = 2;
        @(negedge clk);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h4; hsize = 3'd2;
        @(posedge clk);
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h22222222;
        chk("pre-reset ready", 32'(ro), 32'h0);
        #1 rst = 1'b1;
        #1;
        chk("mid reset ready", 32'(ro), 32'h1);
        chk("mid reset resp", 32'(rr), 32'h0);
        chk("mid reset rdata", rd, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk(2, 0, 32'h4, 3'd2, 32'h0, 32'h11111111, 0, 2), "after reset");

        // Randomised traffic against the byte-level model.
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 16; w++)
                run_model(k, 1'b1, 32'h100 + 32'(4*w), 3'd2, $urandom);
        for (int n = 0; n < 120; n++) begin
            logic [2:0] sz = 3'($urandom_range(0, 4));
            if (sz == 3'd4) sz = 3'($urandom_range(3, 7));
            run_model(int'($urandom_range(0, 1)), 1'($urandom),
                      32'h100 + 32'($urandom_range(0, 63)), sz, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
